// File: rtl/lfsr_tick_scheduler.sv
// lfsr_tick_scheduler: round-robin sharing of one LFSR tick timer among NREQ timeout requesters
module lfsr_tick_scheduler #(
  parameter int NREQ = 4,
  parameter int CW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*CW-1:0] count,
  input  logic              tick,
  output logic              tmr_rst,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              busy
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] rem, rem_n;
  logic [IW-1:0] own, own_n, last, last_n, pick, j;
  logic found, abort, busy_n, tmr_n;
  logic [NREQ-1:0] grant_n, done_n;
  logic [CW-1:0] cnt [NREQ];
  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    assign cnt[g] = count[g*CW +: CW];
  end
  always_comb begin
    found = 1'b0;
    pick = '0;
    j = '0;
    for (int i = 1; i <= NREQ; i++) begin
      j = IW'((int'(last) + i) % NREQ);
      if (!found && req[j]) begin
        found = 1'b1;
        pick = j;
      end
    end
  end
  assign abort = state == RUN && !req[own];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rem <= '0;
      own <= '0;
      last <= IW'(NREQ - 1);
      grant <= '0;
      done <= '0;
      busy <= 1'b0;
      tmr_rst <= 1'b0;
    end else begin
      state <= nxt;
      rem <= rem_n;
      own <= own_n;
      last <= last_n;
      grant <= grant_n;
      done <= done_n;
      busy <= busy_n;
      tmr_rst <= tmr_n;
    end
  end
  // abort outranks a final tick arriving in the same cycle
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = found ? LOAD : IDLE;
      LOAD:    nxt = rem == '0 ? DONE : RUN;
      RUN:     nxt = abort ? IDLE : (tick && rem == CW'(1)) ? DONE : RUN;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    own_n = (state == IDLE && found) ? pick : own;
    rem_n = (state == IDLE && found) ? cnt[pick] :
            (state == RUN && tick && rem != CW'(1)) ? rem - CW'(1) : rem;
    last_n = (state == DONE || abort) ? own : last;
    grant_n = nxt == IDLE ? '0 : NREQ'(1) << own_n;
    done_n = nxt == DONE ? NREQ'(1) << own_n : '0;
    busy_n = nxt != IDLE;
    tmr_n = nxt == RUN;
  end
endmodule
